// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD request arbiter.
// Command layout is {rs, rw, data[7:0]}.
package lcd_pkg;

  localparam int LCD_CMD_W        = 10;
  localparam int LCD_RS_BIT       = 9;
  localparam int LCD_RW_BIT       = 8;
  localparam int LCD_HOLD_DEFAULT = 1501;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_HOLD
  } lcd_arb_state_t;

endpackage

// File: rtl/lcd_req_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the input that did not
// win last time is chosen; a lone valid input always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       win,
  output logic       any
);

  assign any = |valid;
  assign win = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/lcd_req_arbiter.sv
// Round-robin sharer of one LCD driver between two command producers.
// Define LCD_ARB_TIMEOUT_EN to bound the acknowledge wait and flag err.
module lcd_req_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = LCD_HOLD_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [LCD_CMD_W-1:0] req0_bus,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [LCD_CMD_W-1:0] req1_bus,
  output logic                 req1_ready,
  input  logic                 lcd_busy,
  output logic                 lcd_enable,
  output logic [LCD_CMD_W-1:0] lcd_bus,
  output logic                 grant_id,
  output logic                 err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'(HOLD_CYCLES - 1);

  lcd_arb_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LCD_CMD_W-1:0] cmd_q, cmd_d;
  logic                 gid_q, gid_d;
  logic [1:0]           rdy_q, rdy_d;
  logic                 win, any;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  logic err_q, err_d;
`else
  logic unused_ack_to;
  assign unused_ack_to = (ACK_TIMEOUT == 0);
`endif

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (gid_q),
    .win   (win),
    .any   (any)
  );

  // State, counter, command, grant and ready registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      gid_q   <= 1'b1;
      rdy_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      gid_q   <= gid_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  // Sticky acknowledge-timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state: grant, strobe, await ack, then hold off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    gid_d   = gid_q;
    rdy_d   = 2'b00;
`ifdef LCD_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rdy_q[0] && req0_valid) begin
          cmd_d   = req0_bus;
          gid_d   = 1'b0;
          state_d = ST_ISSUE;
        end else if (rdy_q[1] && req1_valid) begin
          cmd_d   = req1_bus;
          gid_d   = 1'b1;
          state_d = ST_ISSUE;
        end else if (rdy_q == 2'b00 && any && !lcd_busy) begin
          rdy_d = win ? 2'b10 : 2'b01;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (lcd_busy) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
`ifdef LCD_ARB_TIMEOUT_EN
        end else if (cnt_q == ACK_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req0_ready = rdy_q[0];
  assign req1_ready = rdy_q[1];
  assign lcd_enable = (state_q == ST_ISSUE);
  assign lcd_bus    = cmd_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Randomized bench for lcd_req_arbiter with a timestamp-based model.
// Build with or without LCD_ARB_TIMEOUT_EN to match the RTL.
module tb_lcd_req_arbiter;
  import lcd_pkg::*;

  localparam int H = 1501;
  localparam int T = 8;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_bus, req1_bus;
  logic       req0_ready, req1_ready;
  logic       lcd_busy, lcd_enable;
  logic [9:0] lcd_bus;
  logic       grant_id, err;

  always #5 clk = ~clk;

  lcd_req_arbiter #(
    .HOLD_CYCLES (H),
    .ACK_TIMEOUT (T),
    .CNT_W       (11)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_bus   (req0_bus),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_bus   (req1_bus),
    .req1_ready (req1_ready),
    .lcd_busy   (lcd_busy),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .grant_id   (grant_id),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int  cyc = 0;
  int  ack_at = -1;
  int  ack_dly = 0;
  bit  ack_en = 1'b1;
  bit  init_busy = 1'b0;
  bit  noise = 1'b0;
  bit  force_busy = 1'b0;
  bit  pop0 = 1'b0;
  bit  pop1 = 1'b0;
  bit  spc_on = 1'b0;
  int  last_en = -1;

  int         en_cyc_q[$];
  logic [9:0] en_bus_q[$];
  logic       en_gid_q[$];

  int         m_dec = -100;
  int         m_free = -1;
  bit         m_known = 1'b0;
  bit         m_win = 1'b0;
  bit         m_gid = 1'b1;
  bit         m_err = 1'b0;
  logic [9:0] m_cmd = '0;
  logic [9:0] m_bus = '0;

  // Requesters and LCD driver stand-in.
  initial begin
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_bus   = '0;
    req1_bus   = '0;
    lcd_busy   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (pop0) begin
        if (q0.size() > 0) void'(q0.pop_front());
        pop0 = 1'b0;
      end
      if (pop1) begin
        if (q1.size() > 0) void'(q1.pop_front());
        pop1 = 1'b0;
      end
      req0_valid = (q0.size() > 0);
      req0_bus   = (q0.size() > 0) ? q0[0] : 10'h000;
      req1_valid = (q1.size() > 0);
      req1_bus   = (q1.size() > 0) ? q1[0] : 10'h000;
      lcd_busy   = init_busy || force_busy
                || (ack_en && cyc == ack_at)
                || (noise && $urandom_range(0, 15) == 0);
    end
  end

  // Per-cycle check against the model, then advance the model.
  always @(negedge clk) begin
    logic [14:0] got, exp;
    logic [1:0]  er;
    if (m_known) begin
      er  = (cyc == m_dec + 1) ? (m_win ? 2'b10 : 2'b01)
                               : 2'b00;
      exp = {er, 1'(cyc == m_dec + 2), m_gid, m_err, m_bus};
      got = {req1_ready, req0_ready, lcd_enable,
             grant_id, err, lcd_bus};
      chk("cyc", 32'(got), 32'(exp));
    end
    if (lcd_enable) begin
      en_cyc_q.push_back(cyc);
      en_bus_q.push_back(lcd_bus);
      en_gid_q.push_back(grant_id);
      if (spc_on && last_en >= 0)
        chk("spacing_min", 32'((cyc - last_en) >= H + 4), 1);
      last_en = cyc;
      if (ack_en) ack_at = cyc + 1 + ack_dly;
    end
    if (req0_valid && req0_ready) pop0 = 1'b1;
    if (req1_valid && req1_ready) pop1 = 1'b1;
    if (!rst_n) begin
      m_known = 1'b1;
      m_dec   = -100;
      m_free  = cyc + 1;
      m_gid   = 1'b1;
      m_err   = 1'b0;
      m_bus   = '0;
      last_en = -1;
    end else if (m_known) begin
      if (cyc == m_dec + 1) begin
        m_bus = m_cmd;
        m_gid = m_win;
      end
      if (m_free < 0) begin
        if (cyc >= m_dec + 3) begin
          if (lcd_busy) m_free = cyc + H + 1;
          else if (TO_EN && cyc - (m_dec + 3) == T - 1) begin
            m_err  = 1'b1;
            m_free = cyc + 1;
          end
        end
      end else if (cyc >= m_free && !lcd_busy
                   && (req0_valid || req1_valid)) begin
        m_win = (req0_valid && req1_valid) ? !m_gid : req1_valid;
        m_cmd = m_win ? req1_bus : req0_bus;
        m_dec = cyc;
        m_free = -1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && m_free >= 0
             && cyc >= m_free) && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, 32'(n < lim), 1);
  endtask

  task automatic clr_log();
    en_cyc_q.delete();
    en_bus_q.delete();
    en_gid_q.delete();
  endtask

  function automatic logic [9:0] mk(input bit rs, input logic [7:0] d);
    logic [9:0] c = '0;
    c[LCD_RS_BIT] = rs;
    c[LCD_RW_BIT] = 1'b0;
    c[7:0] = d;
    return c;
  endfunction

  initial begin
    int s, n;
    logic [9:0] b;
    int r;

    init_busy = 1'b1;
    q0.push_back(mk(1'b1, 8'h41));
    step(3);
    rst_n = 1'b1;
    step(100);
    chk("init_no_en", en_cyc_q.size(), 0);
    chk("init_no_hs", q0.size(), 1);
    init_busy = 1'b0;
    wait_idle(2000, "p1_wait");
    chk("init_bus", 32'(en_bus_q[0]), 32'h241);

    spc_on = 1'b1;
    clr_log();
    q0.push_back(10'h080);
    q0.push_back(10'h080);
    wait_idle(4000, "p2_wait");
    chk("p2_cnt", en_cyc_q.size(), 2);
    chk("p2_spacing", 32'(en_cyc_q[1] - en_cyc_q[0]), H + 4);

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    clr_log();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 8'h41));
      q1.push_back(mk(1'b1, 8'h42));
    end
    wait_idle(8 * 1600, "p3_wait");
    chk("p3_cnt", en_gid_q.size(), 8);
    for (int i = 0; i < en_gid_q.size(); i++) begin
      chk("alt_gid", 32'(en_gid_q[i]), i % 2);
      chk("alt_bus", 32'(en_bus_q[i]),
          (i % 2) ? 32'h242 : 32'h041);
    end

    clr_log();
    ack_dly = 0;
    q0.push_back(10'h155);
    n = 0;
    while (en_cyc_q.size() == 0 && n < 100) begin
      step(1);
      n++;
    end
    chk("p4_en", en_cyc_q.size(), 1);
    s = (en_cyc_q.size() > 0) ? en_cyc_q[0] : cyc;
    while (cyc < s + 802) step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vals",
        32'({req1_ready, req0_ready, lcd_enable,
             grant_id, err, lcd_bus}),
        32'({2'b00, 1'b0, 1'b1, 1'b0, 10'h000}));
    clr_log();
    step(2000);
    chk("no_reissue", en_cyc_q.size(), 0);

    noise = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 3);
      ack_dly = $urandom_range(0, 3);
      if (r != 1) begin
        b = 10'($urandom_range(0, 1023));
        q0.push_back(b);
      end
      if (r != 0) begin
        b = 10'($urandom_range(0, 1023));
        q1.push_back(b);
      end
      step($urandom_range(0, 30));
      wait_idle(6000, "p5_wait");
    end
    noise = 1'b0;

    spc_on = 1'b0;
    ack_en = 1'b0;
    ack_dly = 0;
    q0.push_back(10'h1AA);
    step(T * 4 + 20);
    chk("err_to", 32'(err), 32'(TO_EN));
    force_busy = 1'b1;
    step(1);
    force_busy = 1'b0;
    ack_en = 1'b1;
    clr_log();
    q1.push_back(10'h0F0);
    wait_idle(4000, "p6_wait");
    chk("err_hold", 32'(err), 32'(TO_EN));
    chk("p6_bus", 32'(en_bus_q[0]), 32'h0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
